mat3_stream_loader: RTL and testbench

//  Upstream feeder for the combinational 3x3 determinant unit. Accepts matrix elements serially, row-major
//  (a,b,c,d,e,f,g,h,i), over a valid/ready stream. Holds the nine elements stable on a flat bus, waits a

---
 rtl/mat3_stream_loader_pkg.sv | 45 ++++
 rtl/mat3_stream_loader_if.sv | 33 +++
 rtl/mat3_stream_loader_elem_counter.sv | 36 +++
 rtl/mat3_stream_loader.sv | 204 ++++++++++++++++++++
 tb/tb_mat3_stream_loader.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mat3_stream_loader_pkg.sv
// Shared types and constants for the 3x3 matrix stream loader.
// Holds the FSM state encoding, element-count widths, slot indices
// for the row-major elements a..i, and a slot-select decoder.
package mat3_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_e;

    localparam int N_ELEM   = 9;
    localparam int CNT_W    = 4;
    localparam int SETTLE_W = 4;

    // Row-major slot indices: a b c / d e f / g h i
    localparam logic [CNT_W-1:0] IDX_A = 4'd0;
    localparam logic [CNT_W-1:0] IDX_B = 4'd1;
    localparam logic [CNT_W-1:0] IDX_C = 4'd2;
    localparam logic [CNT_W-1:0] IDX_D = 4'd3;
    localparam logic [CNT_W-1:0] IDX_E = 4'd4;
    localparam logic [CNT_W-1:0] IDX_F = 4'd5;
    localparam logic [CNT_W-1:0] IDX_G = 4'd6;
    localparam logic [CNT_W-1:0] IDX_H = 4'd7;
    localparam logic [CNT_W-1:0] IDX_I = 4'd8;

    // One-hot slot select for an element index; out-of-range selects nothing
    function automatic logic [N_ELEM-1:0] slot_decode(input logic [CNT_W-1:0] idx);
        logic [N_ELEM-1:0] sel;
        case (idx)
            IDX_A:   sel = 9'b000000001;
            IDX_B:   sel = 9'b000000010;
            IDX_C:   sel = 9'b000000100;
            IDX_D:   sel = 9'b000001000;
            IDX_E:   sel = 9'b000010000;
            IDX_F:   sel = 9'b000100000;
            IDX_G:   sel = 9'b001000000;
            IDX_H:   sel = 9'b010000000;
            IDX_I:   sel = 9'b100000000;
            default: sel = 9'b000000000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mat3_stream_loader_if.sv
// Element input stream and determinant result stream of the loader.
// slave: loader side. master: producer/consumer side.
interface mat3_stream_loader_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  res_ready,
        output in_ready,
        output res_valid,
        output res_data
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output res_ready,
        input  in_ready,
        input  res_valid,
        input  res_data
    );
endinterface

// File: rtl/mat3_stream_loader_elem_counter.sv
// Modulo-9 element index counter. Clear has priority over increment;
// is_last flags the index of element i so framing can be checked.
module mat3_elem_counter
    import mat3_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             is_last
);

    logic [CNT_W-1:0] count_r;

    // element index: clear, or advance and wrap after element i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            if (count_r == IDX_I) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign count   = count_r;
    assign is_last = (count_r == IDX_I);

endmodule

// File: rtl/mat3_stream_loader.sv
// Serial feeder for a combinational 3x3 determinant unit.
// Collects nine row-major elements, freezes them on mat_flat for
// SETTLE_CYC cycles, captures det_result and offers it on the result stream.
// Optional build macro MAT3_SOFT_CLR_EN adds a synchronous soft_clr input.
module mat3_stream_loader
    import mat3_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int SETTLE_CYC = 2    // legal 1..15
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef MAT3_SOFT_CLR_EN
    input  logic                     soft_clr,
`endif
    mat3_stream_loader_if.slave      bus,
    output logic [N_ELEM*DATA_W-1:0] mat_flat,
    input  logic [DATA_W-1:0]        det_result,
    output logic                     frame_err,
    output logic                     busy
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_ZERO = {SETTLE_W{1'b0}};
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = {{(SETTLE_W-1){1'b0}}, 1'b1};

    state_e                     state_r;
    state_e                     state_nxt_s;
    logic [SETTLE_W-1:0]        settle_cnt_r;
    logic [N_ELEM*DATA_W-1:0]   mat_flat_r;
    logic [DATA_W-1:0]          res_data_r;
    logic                       res_valid_r;
    logic                       in_ready_r;
    logic                       frame_err_r;
    logic                       busy_r;

    logic                       soft_clr_s;
    logic                       err_s;
    logic                       wr_s;
    logic                       frame_done_s;
    logic                       capture_s;
    logic                       res_hs_s;
    logic                       cnt_clr_s;
    logic                       cnt_inc_s;
    logic [CNT_W-1:0]           cnt_s;
    logic                       cnt_is_last_s;
    logic [N_ELEM-1:0]          slot_sel_s;

`ifdef MAT3_SOFT_CLR_EN
    assign soft_clr_s = soft_clr;
`else
    assign soft_clr_s = 1'b0;
`endif

    mat3_elem_counter u_elem_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr_s),
        .inc     (cnt_inc_s),
        .count   (cnt_s),
        .is_last (cnt_is_last_s)
    );

    assign slot_sel_s = slot_decode(cnt_s);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next state, framing decisions and counter control
    always_comb begin
        state_nxt_s  = state_r;
        err_s        = 1'b0;
        wr_s         = 1'b0;
        frame_done_s = 1'b0;
        capture_s    = 1'b0;
        res_hs_s     = 1'b0;
        cnt_clr_s    = 1'b0;
        cnt_inc_s    = 1'b0;
        if (soft_clr_s) begin
            // soft clear wins over any handshake in the same cycle
            state_nxt_s = LOAD;
            cnt_clr_s   = 1'b1;
        end else begin
            case (state_r)
                LOAD: begin
                    if (bus.in_valid && in_ready_r) begin
                        if (bus.in_last != cnt_is_last_s) begin
                            // in_last early, or missing on element i: drop and restart
                            err_s     = 1'b1;
                            cnt_clr_s = 1'b1;
                        end else begin
                            wr_s      = 1'b1;
                            cnt_inc_s = 1'b1;
                            if (cnt_is_last_s) begin
                                frame_done_s = 1'b1;
                                state_nxt_s  = SETTLE;
                            end else begin
                                state_nxt_s  = LOAD;
                            end
                        end
                    end else begin
                        state_nxt_s = LOAD;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_r == SETTLE_ZERO) begin
                        capture_s   = 1'b1;
                        state_nxt_s = OUT;
                    end else begin
                        state_nxt_s = SETTLE;
                    end
                end
                OUT: begin
                    if (res_valid_r && bus.res_ready) begin
                        res_hs_s    = 1'b1;
                        cnt_clr_s   = 1'b1;
                        state_nxt_s = LOAD;
                    end else begin
                        state_nxt_s = OUT;
                    end
                end
                default: begin
                    state_nxt_s = LOAD;
                    cnt_clr_s   = 1'b1;
                end
            endcase
        end
    end

    // settle window countdown, armed by the last element of a good frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt_r <= SETTLE_ZERO;
        end else if (frame_done_s) begin
            settle_cnt_r <= SETTLE_LOAD;
        end else if (state_r == SETTLE && settle_cnt_r != SETTLE_ZERO && !soft_clr_s) begin
            settle_cnt_r <= settle_cnt_r - SETTLE_ONE;
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    // element register file: an accepted element lands in its indexed slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_flat_r <= {(N_ELEM*DATA_W){1'b0}};
        end else if (wr_s) begin
            for (int k = 0; k < N_ELEM; k++) begin
                if (slot_sel_s[k]) begin
                    mat_flat_r[k*DATA_W +: DATA_W] <= bus.in_data;
                end
            end
        end else begin
            mat_flat_r <= mat_flat_r;
        end
    end

    // result register: determinant captured verbatim at the end of settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_r  <= {DATA_W{1'b0}};
            res_valid_r <= 1'b0;
        end else if (soft_clr_s) begin
            res_data_r  <= res_data_r;
            res_valid_r <= 1'b0;
        end else if (capture_s) begin
            res_data_r  <= det_result;
            res_valid_r <= 1'b1;
        end else if (res_hs_s) begin
            res_data_r  <= res_data_r;
            res_valid_r <= 1'b0;
        end else begin
            res_data_r  <= res_data_r;
            res_valid_r <= res_valid_r;
        end
    end

    // registered status outputs derived from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == LOAD);
            busy_r      <= (state_nxt_s != LOAD);
            frame_err_r <= err_s;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign mat_flat      = mat_flat_r;
    assign frame_err     = frame_err_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_mat3_stream_loader.sv
// Directed self-checking bench for mat3_stream_loader (SETTLE_CYC=2).
// A behavioural determinant unit drives det_result from mat_flat;
// expected results are hand-computed constants.
module tb_mat3_stream_loader;
    import mat3_pkg::*;

    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [9*DW-1:0]   mat_flat;
    logic [DW-1:0]     det_result;
    logic              frame_err;
    logic              busy;
`ifdef MAT3_SOFT_CLR_EN
    logic              soft_clr;
`endif

    int errors = 0;
    int checks = 0;
    int dm [9];

    int f1 [9] = '{1, 1, 1, 2, 1, 2, 1, 1, 2};
    int f2 [9] = '{-1, -4, -7, -2, -3, -8, -1, -2, -7};
    int f3 [9] = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
    int f4 [9] = '{0, 1, 2, 3, 1, 2, 3, 0, 0};

    mat3_stream_loader_if #(.DATA_W(DW)) bus ();

    mat3_stream_loader #(.DATA_W(DW), .SETTLE_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef MAT3_SOFT_CLR_EN
        .soft_clr   (soft_clr),
`endif
        .bus        (bus),
        .mat_flat   (mat_flat),
        .det_result (det_result),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // behavioural determinant unit, mod 2^DW
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            dm[k] = int'($signed(mat_flat[k*DW +: DW]));
        end
        det_result = DW'(dm[0]*(dm[4]*dm[8] - dm[5]*dm[7])
                       - dm[1]*(dm[3]*dm[8] - dm[5]*dm[6])
                       + dm[2]*(dm[3]*dm[7] - dm[4]*dm[6]));
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] pack(input int f [9]);
        logic [71:0] p;
        p = 72'd0;
        for (int k = 0; k < 9; k++) begin
            p[k*DW +: DW] = DW'(f[k]);
        end
        return p;
    endfunction

    // offer one element and return just after the edge that takes it
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            check("in_ready_timeout", 72'(bus.in_ready), 72'(1'b1));
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input int f [9], input bit gap);
        for (int k = 0; k < 9; k++) begin
            send(DW'(f[k]), (k == 8));
            if (gap && k < 8) begin
                tick();
            end
        end
    endtask

    // from just after the last accept edge: result appears on the 2nd edge after it
    task automatic settle_check(input logic [7:0] exp, input logic [71:0] mexp);
        check("acc_in_ready",   72'(bus.in_ready),  72'(1'b0));
        check("acc_busy",       72'(busy),          72'(1'b1));
        check("acc_res_valid",  72'(bus.res_valid), 72'(1'b0));
        check("acc_mat_flat",   72'(mat_flat),      mexp);
        tick();
        check("s1_res_valid",   72'(bus.res_valid), 72'(1'b0));
        check("s1_in_ready",    72'(bus.in_ready),  72'(1'b0));
        check("s1_mat_flat",    72'(mat_flat),      mexp);
        tick();
        check("s2_res_valid",   72'(bus.res_valid), 72'(1'b1));
        check("s2_res_data",    72'(bus.res_data),  72'(exp));
        check("s2_mat_flat",    72'(mat_flat),      mexp);
        check("s2_in_ready",    72'(bus.in_ready),  72'(1'b0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b0;
`ifdef MAT3_SOFT_CLR_EN
        soft_clr      = 1'b0;
`endif
        tick();
        tick();
        check("rst_in_ready",  72'(bus.in_ready),  72'(1'b0));
        check("rst_res_valid", 72'(bus.res_valid), 72'(1'b0));
        check("rst_res_data",  72'(bus.res_data),  72'(8'h00));
        check("rst_mat_flat",  72'(mat_flat),      72'd0);
        check("rst_busy",      72'(busy),          72'(1'b0));
        check("rst_frame_err", 72'(frame_err),     72'(1'b0));
        rst_n = 1'b1;
        check("rel_in_ready",  72'(bus.in_ready),  72'(1'b0));
        tick();
        check("first_in_ready", 72'(bus.in_ready), 72'(1'b1));

        // frame 1: det = -1
        bus.res_ready = 1'b1;
        send_frame(f1, 1'b0);
        settle_check(8'hFF, pack(f1));
        tick();
        check("f1_hs_res_valid", 72'(bus.res_valid), 72'(1'b0));
        check("f1_hs_in_ready",  72'(bus.in_ready),  72'(1'b1));
        check("f1_hs_busy",      72'(busy),          72'(1'b0));

        // frame 2, gapped: det = 12
        bus.res_ready = 1'b0;
        send_frame(f2, 1'b1);
        settle_check(8'h0C, pack(f2));
        tick();
        check("f2_hold_res_valid", 72'(bus.res_valid), 72'(1'b1));
        check("f2_hold_mat_flat",  72'(mat_flat),      pack(f2));
        bus.res_ready = 1'b1;
        tick();
        check("f2_hs_res_valid", 72'(bus.res_valid), 72'(1'b0));
        check("f2_hs_in_ready",  72'(bus.in_ready),  72'(1'b1));

        // frame 3, all 3s, consumer stalls with input offered: det = 0
        bus.res_ready = 1'b0;
        send_frame(f3, 1'b0);
        settle_check(8'h00, pack(f3));
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("f3_stall_res_valid", 72'(bus.res_valid), 72'(1'b1));
            check("f3_stall_res_data",  72'(bus.res_data),  72'(8'h00));
            check("f3_stall_in_ready",  72'(bus.in_ready),  72'(1'b0));
            check("f3_stall_mat_flat",  72'(mat_flat),      pack(f3));
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        check("f3_hs_res_valid", 72'(bus.res_valid), 72'(1'b0));
        check("f3_hs_in_ready",  72'(bus.in_ready),  72'(1'b1));

        // early in_last on the 5th element
        send(8'd1, 1'b0);
        send(8'd1, 1'b0);
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd1, 1'b1);
        check("e1_frame_err",  72'(frame_err),    72'(1'b1));
        check("e1_in_ready",   72'(bus.in_ready), 72'(1'b1));
        check("e1_busy",       72'(busy),         72'(1'b0));
        tick();
        check("e1_frame_err_pulse", 72'(frame_err),     72'(1'b0));
        tick();
        check("e1_no_result",       72'(bus.res_valid), 72'(1'b0));
        send_frame(f4, 1'b0);
        settle_check(8'h00, pack(f4));
        tick();
        check("f4_hs_res_valid", 72'(bus.res_valid), 72'(1'b0));

        // nine elements with no in_last
        for (int k = 0; k < 9; k++) begin
            send(DW'(f1[k]), 1'b0);
        end
        check("e2_frame_err", 72'(frame_err), 72'(1'b1));
        check("e2_busy",      72'(busy),      72'(1'b0));
        tick();
        check("e2_frame_err_pulse", 72'(frame_err),     72'(1'b0));
        tick();
        tick();
        check("e2_no_result",       72'(bus.res_valid), 72'(1'b0));

        // asynchronous reset after five elements of a new frame
        for (int k = 0; k < 5; k++) begin
            send(DW'(f2[k]), 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_in_ready",  72'(bus.in_ready),  72'(1'b0));
        check("ar_res_valid", 72'(bus.res_valid), 72'(1'b0));
        check("ar_mat_flat",  72'(mat_flat),      72'd0);
        check("ar_res_data",  72'(bus.res_data),  72'(8'h00));
        check("ar_busy",      72'(busy),          72'(1'b0));
        check("ar_frame_err", 72'(frame_err),     72'(1'b0));
        tick();
        rst_n = 1'b1;
        send_frame(f1, 1'b0);
        settle_check(8'hFF, pack(f1));
        tick();
        check("ar_hs_res_valid", 72'(bus.res_valid), 72'(1'b0));

`ifdef MAT3_SOFT_CLR_EN
        // soft clear while a result waits in OUT
        bus.res_ready = 1'b0;
        send_frame(f2, 1'b0);
        settle_check(8'h0C, pack(f2));
        soft_clr = 1'b1;
        tick();
        soft_clr = 1'b0;
        check("sc_res_valid", 72'(bus.res_valid), 72'(1'b0));
        check("sc_in_ready",  72'(bus.in_ready),  72'(1'b1));
        check("sc_busy",      72'(busy),          72'(1'b0));
        check("sc_res_data",  72'(bus.res_data),  72'(8'h0C));
        check("sc_mat_flat",  72'(mat_flat),      pack(f2));
        bus.res_ready = 1'b1;
        send_frame(f1, 1'b0);
        settle_check(8'hFF, pack(f1));
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
